uart_rx: RTL
============

# uart_rx

Receive-side deserializer for the UART. It consumes the 16× oversampling tick from the baud generator and synchronizes the asynchronous `rx` pin. It detects and validates start bits, samples each data bit at mid-bit, checks the stop bit, and presents each received byte on a valid/ready interface to the host-side logic. Framing and overrun errors are reported as single-cycle pulses.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, 5–9, LSB first; no parity.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `baud_x16_tick`  in  1  one-cycle pulse at 16× the baud rate, from the baud generator.
- `rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  DATA_BITS  received word; stable while `rx_valid`=1.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid`&&`rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: a new word completed while the previous word was still unconsumed.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1, giving `rx_s`.
- `tick_cnt` is 4 bits. It advances only on `baud_x16_tick` and is cleared on every state entry. `bit_idx` is a counter of width $clog2(DATA_BITS).
- FSM states and transitions:
  - IDLE: on a tick with `rx_s`=0 → START.
  - START: on the tick where `tick_cnt`==7 (mid start bit), sample. Sample 1 → IDLE (glitch rejected, no error). Sample 0 → DATA, with `bit_idx`=0.
  - DATA: on the tick where `tick_cnt`==15, sample and shift into the MSB of the shift register (right-shift, LSB first). After the DATA_BITS-th sample → STOP; otherwise `bit_idx`+1.
  - STOP: on the tick where `tick_cnt`==15, sample, then → IDLE.
    - Sample 0 → `frame_err` pulse; the word is discarded.
    - Sample 1 → deliver the word.
- Delivery rules:
  - If `rx_valid`=0, or `rx_valid`&&`rx_ready` in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: `overrun_err` pulse; `rx_data` keeps the old word; the new word is dropped.
- `rx_valid` clears in the cycle after `rx_valid`&&`rx_ready`, unless a new word loads in that same cycle (see delivery rules).
- A held-low line (break) produces a `frame_err` every frame time, with no `rx_valid`.
- `baud_x16_tick` is not required to be continuous. The FSM freezes between ticks. The baud generator being disabled mid-frame stalls the frame and does not abort it.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `busy`=0, FSM=IDLE, synchronizer=1.
- All outputs are registered.
- `rx` to `rx_s` latency: 2 clocks.
- The start edge is detected on the first tick after `rx_s` falls. Start is validated 8 ticks later; data bit n is sampled 16·(n+1)+8 ticks after detection.
- `rx_valid` and `frame_err` assert on the clock edge after the stop-sample tick. `overrun_err` likewise.
- `busy` rises the cycle after the start detect and falls with the return to IDLE.
- Reset asserted mid-frame: all state returns to reset values immediately. The next falling edge on `rx_s` starts a fresh frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - A 3-bit history holds `rx_s` captured on the last three ticks.
  - Every sample point (start, data, stop) uses the 2-of-3 majority of the samples at `tick_cnt` = sample−2, sample−1, sample.
  - A single-tick glitch at a sample point is rejected.
- Not defined: the single `rx_s` value at the sample tick is used; no history register.

## Structure
- Package `uart_pkg`:
  - `uart_rx_state_t` enum {IDLE, START, DATA, STOP}.
  - Constants `OVERSAMPLE`=16, `START_SAMPLE`=7, `BIT_SAMPLE`=15.
- Sub-module `uart_sync2`: generic 2-flop synchronizer with a reset-value parameter. Instantiated once for `rx`.

## Test plan
All scenarios use `DATA_BITS`=8, with the bench driving `baud_x16_tick` every 4 clocks.
- Frame 0x55, valid stop bit, `rx_ready`=1 → `rx_data`=0x55, `rx_valid` high for exactly 1 cycle, `frame_err`=0, `busy` low after the stop bit.
- `rx` low for 4 ticks, then high → returns to IDLE at the mid-start check; no `rx_valid`, no errors.
- Frame 0xA3 with stop bit 0 → `frame_err` 1-cycle pulse; `rx_valid` stays 0.
- `rx_ready`=0; send 0x12, then 0x34 → `rx_data` holds 0x12, `overrun_err` pulses at the 0x34 stop sample. Raise `rx_ready` → 0x12 consumed, then `rx_valid`=0.
- Assert `rst_n` low during data bit 3 → all outputs at reset values. A following frame 0xC3 is received as 0xC3.
- Frame 0x00 with a 1-tick high glitch at the bit-2 sample point → with the macro: 0x00; without the macro: 0x04.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   // Receiver frame-tracking states.
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_rx_state_t;

   // Oversampling ratio of the baud tick relative to the bit rate.
   localparam int OVERSAMPLE = 16;
   localparam int TICK_W     = $clog2(OVERSAMPLE);

   // Tick count at which the start bit is checked (middle of the start bit).
   localparam logic [TICK_W-1:0] START_SAMPLE = TICK_W'(7);
   // Tick count at which data and stop bits are sampled; because the count is
   // re-zeroed at mid start bit, this lands in the middle of each later bit.
   localparam logic [TICK_W-1:0] BIT_SAMPLE   = TICK_W'(15);

   // 2-of-3 vote used to suppress single-tick glitches at sample points.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level input.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] stages;

   // Shift the asynchronous input through two flops; reset to the idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= {2{RESET_VAL}};
      end else begin
         stages <= {stages[0], d};
      end
   end

   assign q = stages[1];

endmodule

// File: rtl/uart_rx.sv
// UART receive deserializer: 16x oversampled start/data/stop recovery with a
// valid/ready output and single-cycle framing and overrun error pulses.
// Optional build macro UART_RX_MAJORITY_EN: each sample point uses a 2-of-3
// majority over the last three ticks instead of the single tick value.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_x16_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int                IDX_W    = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 sample_bit;
   uart_rx_state_t       state;
   logic [TICK_W-1:0]    tick_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // The two previous ticks are held here; together with the live rx_s at
   // the current tick they form the three-tick history that gets voted on.
   logic [1:0] hist;

   // Capture rx_s on every tick, in every state, so the history is always
   // primed when a sample point arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= 2'b11;
      end else if (baud_x16_tick) begin
         hist <= {hist[0], rx_s};
      end
   end

   assign sample_bit = majority3(hist[1], hist[0], rx_s);
`else
   assign sample_bit = rx_s;
`endif

   // Frame FSM plus registered delivery/error outputs; everything advances
   // only on a baud tick, so a paused tick stream freezes the frame in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;

         // Handshake completion; a word loading this same cycle overrides it.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (baud_x16_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state    <= START;
                     tick_cnt <= '0;
                     busy     <= 1'b1;
                  end
               end

               START: begin
                  if (tick_cnt == START_SAMPLE) begin
                     tick_cnt <= '0;
                     if (sample_bit) begin
                        // Line went back high before mid start bit: glitch.
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end
                  end
               end

               DATA: begin
                  if (tick_cnt == BIT_SAMPLE) begin
                     // LSB arrives first, so shift right and insert at the MSB.
                     shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
                     tick_cnt  <= '0;
                     if (bit_idx == LAST_IDX) begin
                        state <= STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end
               end

               STOP: begin
                  if (tick_cnt == BIT_SAMPLE) begin
                     state    <= IDLE;
                     tick_cnt <= '0;
                     busy     <= 1'b0;
                     if (!sample_bit) begin
                        frame_err <= 1'b1;
                     end else if (!rx_valid || rx_ready) begin
                        rx_data  <= shift_reg;
                        rx_valid <= 1'b1;
                     end else begin
                        // Previous word still pending: keep it, drop this one.
                        overrun_err <= 1'b1;
                     end
                  end
               end

               default: begin
                  state    <= IDLE;
                  tick_cnt <= '0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
